// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Storage is an inferred RAM with a synchronous read port feeding a one-word
// output stage (dout_q / valid_q). The occupancy count covers the RAM words
// plus the word held in the output stage, so DEPTH words fit in total.
//
// Handshake: a write is accepted on a rising edge when wr_en & !full &
// !wr_rst_busy, and a read when rd_en & !empty & !rd_rst_busy. The
// wr_ack, overflow and underflow strobes report the outcome one cycle later.
// A word pushed into an empty FIFO reaches dout one edge after it is stored.
`timescale 1ns/1ps

module sync_fwft_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  wr_rst_busy,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  data_valid,
    output logic                  underflow,
    output logic                  rd_rst_busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // RAM storage (no reset so it can map onto block memory)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      ram_cnt;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q, valid_d;
    logic                  full_q, full_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  overflow_d, underflow_d;
    logic [1:0]            busy_q;
    logic                  busy;
    logic                  push, pop, load;

    assign busy = busy_q[1];

    // Accept/reject decisions, output-stage refill and next-state bookkeeping
    always_comb begin
        push        = wr_en & ~full_q & ~busy;
        pop         = rd_en & valid_q & ~busy;
        overflow_d  = wr_en & (full_q | busy);
        underflow_d = rd_en & (~valid_q | busy);
        // Words sitting in the RAM, excluding the one in the output stage
        ram_cnt     = count_q - CNT_W'(valid_q);
        // Refill the output stage when it is empty or being popped this cycle
        load        = (ram_cnt != '0) & (~valid_q | pop);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d = (count_d == DEPTH_CNT);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (load) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // RAM write port
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Control state, output stage and status strobes; reset clears everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            full_q      <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 2'b11;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            full_q      <= full_d;
            wr_ack_q    <= push;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            // Busy stays up for two edges after reset release
            busy_q      <= {busy_q[0], 1'b0};
            if (load) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign full        = full_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign wr_rst_busy = busy;
    assign rd_rst_busy = busy;
    assign dout        = dout_q;
    assign empty       = ~valid_q;
    assign data_valid  = valid_q;

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Directed testbench for sync_fwft_fifo (32 x 8192).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_sync_fwft_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8192;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full, wr_ack, overflow, wr_rst_busy;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty, data_valid, underflow, rd_rst_busy;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    sync_fwft_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_en(wr_en), .din(din), .full(full), .wr_ack(wr_ack),
        .overflow(overflow), .wr_rst_busy(wr_rst_busy),
        .rd_en(rd_en), .dout(dout), .empty(empty), .data_valid(data_valid),
        .underflow(underflow), .rd_rst_busy(rd_rst_busy)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // Pop until the FIFO shows empty, comparing each head word with the model
    task automatic drain(output int n);
        logic [DW-1:0] exp;
        n = 0;
        for (int k = 0; k < DEPTH + 16; k++) begin
            if (!data_valid) break;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL drain_extra: got %h, expected no word", dout);
            end else begin
                exp = exp_q.pop_front();
                if (dout !== exp) begin
                    errors++; $display("FAIL drain_data[%0d]: got %h, expected %h", n, dout, exp);
                end
            end
            rd_en = 1'b1;
            n++;
            @(negedge clk_i);
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b, expected 1", empty); end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        repeat (3) @(negedge clk_i);
        checks += 9;
        if (empty !== 1'b1)       begin errors++; $display("FAIL rst_empty: got %b, expected 1", empty); end
        if (data_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b, expected 0", data_valid); end
        if (dout !== '0)          begin errors++; $display("FAIL rst_dout: got %h, expected 0", dout); end
        if (full !== 1'b0)        begin errors++; $display("FAIL rst_full: got %b, expected 0", full); end
        if (wr_ack !== 1'b0)      begin errors++; $display("FAIL rst_wr_ack: got %b, expected 0", wr_ack); end
        if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
        if (underflow !== 1'b0)   begin errors++; $display("FAIL rst_underflow: got %b, expected 0", underflow); end
        if (wr_rst_busy !== 1'b1) begin errors++; $display("FAIL rst_wr_busy: got %b, expected 1", wr_rst_busy); end
        if (rd_rst_busy !== 1'b1) begin errors++; $display("FAIL rst_rd_busy: got %b, expected 1", rd_rst_busy); end

        // Release reset and probe both sides while still busy
        rst_ni = 1'b1; wr_en = 1'b1; din = 32'hDEAD0001; rd_en = 1'b1;
        @(negedge clk_i);
        checks += 6;
        if (wr_rst_busy !== 1'b1) begin errors++; $display("FAIL busy1_wr: got %b, expected 1", wr_rst_busy); end
        if (rd_rst_busy !== 1'b1) begin errors++; $display("FAIL busy1_rd: got %b, expected 1", rd_rst_busy); end
        if (overflow !== 1'b1)    begin errors++; $display("FAIL busy_overflow: got %b, expected 1", overflow); end
        if (underflow !== 1'b1)   begin errors++; $display("FAIL busy_underflow: got %b, expected 1", underflow); end
        if (wr_ack !== 1'b0)      begin errors++; $display("FAIL busy_wr_ack: got %b, expected 0", wr_ack); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL busy_empty: got %b, expected 1", empty); end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk_i);
        checks += 6;
        if (wr_rst_busy !== 1'b0) begin errors++; $display("FAIL busy2_wr: got %b, expected 0", wr_rst_busy); end
        if (rd_rst_busy !== 1'b0) begin errors++; $display("FAIL busy2_rd: got %b, expected 0", rd_rst_busy); end
        if (overflow !== 1'b0)    begin errors++; $display("FAIL busy2_overflow: got %b, expected 0", overflow); end
        if (underflow !== 1'b0)   begin errors++; $display("FAIL busy2_underflow: got %b, expected 0", underflow); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL busy2_empty: got %b, expected 1", empty); end
        if (dout !== '0)          begin errors++; $display("FAIL busy2_dout: got %h, expected 0", dout); end
    endtask

    task automatic test_single_word();
        wr_en = 1'b1; din = 32'h00010241;
        @(negedge clk_i);
        wr_en = 1'b0;
        checks += 2;
        if (wr_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b, expected 1", wr_ack); end
        if (empty !== 1'b1)  begin errors++; $display("FAIL single_latency: got empty=%b, expected 1", empty); end
        @(negedge clk_i);
        checks += 4;
        if (wr_ack !== 1'b0)     begin errors++; $display("FAIL single_ack_pulse: got %b, expected 0", wr_ack); end
        if (data_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", data_valid); end
        if (empty !== 1'b0)      begin errors++; $display("FAIL single_empty: got %b, expected 0", empty); end
        if (dout !== 32'h00010241) begin errors++; $display("FAIL single_dout: got %h, expected 00010241", dout); end
        rd_en = 1'b1;
        @(negedge clk_i);
        rd_en = 1'b0;
        checks += 4;
        if (empty !== 1'b1)      begin errors++; $display("FAIL single_pop_empty: got %b, expected 1", empty); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b, expected 0", data_valid); end
        if (underflow !== 1'b0)  begin errors++; $display("FAIL single_pop_underflow: got %b, expected 0", underflow); end
        if (dout !== 32'h00010241) begin errors++; $display("FAIL single_dout_hold: got %h, expected 00010241", dout); end
    endtask

    task automatic test_fill();
        int n;
        logic [DW-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; din = DW'(i); exp_q.push_back(DW'(i));
            @(negedge clk_i);
            checks += 2;
            if (wr_ack !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d]: got %b, expected 1", i, wr_ack); end
            if (full !== (i == DEPTH - 1)) begin
                errors++; $display("FAIL fill_full[%0d]: got %b, expected %b", i, full, (i == DEPTH - 1));
            end
        end
        // One extra write while full
        din = 32'hBAD0BAD0;
        @(negedge clk_i);
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b, expected 1", overflow); end
        if (wr_ack !== 1'b0)   begin errors++; $display("FAIL full_no_ack: got %b, expected 0", wr_ack); end
        if (full !== 1'b1)     begin errors++; $display("FAIL full_hold: got %b, expected 1", full); end
        // Write and read together while full: the read does not make room
        din = 32'hBAD1BAD1; rd_en = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL full_head: got %h, expected %h", dout, exp); end
        @(negedge clk_i);
        wr_en = 1'b0; rd_en = 1'b0;
        checks += 4;
        if (overflow !== 1'b1)  begin errors++; $display("FAIL full_rw_overflow: got %b, expected 1", overflow); end
        if (wr_ack !== 1'b0)    begin errors++; $display("FAIL full_rw_no_ack: got %b, expected 0", wr_ack); end
        if (full !== 1'b0)      begin errors++; $display("FAIL full_rw_full: got %b, expected 0", full); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL full_rw_underflow: got %b, expected 0", underflow); end
        drain(n);
        checks++;
        if (n != DEPTH - 1) begin errors++; $display("FAIL fill_drain_count: got %0d, expected %0d", n, DEPTH - 1); end
    endtask

    task automatic test_underflow();
        int n;
        rd_en = 1'b1;
        @(negedge clk_i);
        rd_en = 1'b0;
        checks += 2;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse: got %b, expected 1", underflow); end
        if (empty !== 1'b1)     begin errors++; $display("FAIL uf_empty: got %b, expected 1", empty); end
        @(negedge clk_i);
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b, expected 0", underflow); end
        // Write into empty FIFO with a simultaneous read
        wr_en = 1'b1; rd_en = 1'b1; din = 32'h00C0FFEE; exp_q.push_back(32'h00C0FFEE);
        @(negedge clk_i);
        wr_en = 1'b0; rd_en = 1'b0;
        checks += 3;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf_wr_underflow: got %b, expected 1", underflow); end
        if (wr_ack !== 1'b1)    begin errors++; $display("FAIL uf_wr_ack: got %b, expected 1", wr_ack); end
        if (empty !== 1'b1)     begin errors++; $display("FAIL uf_wr_empty: got %b, expected 1", empty); end
        @(negedge clk_i);
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf_wr_clear: got %b, expected 0", underflow); end
        drain(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL uf_drain_count: got %0d, expected 1", n); end
    endtask

    task automatic test_streaming();
        int n;
        logic [DW-1:0] v;
        logic [DW-1:0] exp;
        for (int i = 0; i < DEPTH / 2; i++) begin
            v = 32'hA5000000 ^ DW'(i);
            wr_en = 1'b1; din = v; exp_q.push_back(v);
            @(negedge clk_i);
        end
        for (int k = 0; k < 20000; k++) begin
            checks += 3;
            if (data_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b, expected 1", k, data_valid); end
            if (full !== 1'b0)       begin errors++; $display("FAIL stream_full[%0d]: got %b, expected 0", k, full); end
            exp = exp_q.pop_front();
            if (dout !== exp) begin errors++; $display("FAIL stream_data[%0d]: got %h, expected %h", k, dout, exp); end
            v = 32'h5A000000 ^ DW'(k);
            wr_en = 1'b1; din = v; exp_q.push_back(v); rd_en = 1'b1;
            @(negedge clk_i);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        drain(n);
        checks++;
        if (n != DEPTH / 2) begin errors++; $display("FAIL stream_occupancy: got %0d, expected %0d", n, DEPTH / 2); end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; din = 32'h77000000 + DW'(i); exp_q.push_back(din);
            @(negedge clk_i);
        end
        wr_en = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checks += 5;
        if (empty !== 1'b1)       begin errors++; $display("FAIL midrst_empty: got %b, expected 1", empty); end
        if (full !== 1'b0)        begin errors++; $display("FAIL midrst_full: got %b, expected 0", full); end
        if (data_valid !== 1'b0)  begin errors++; $display("FAIL midrst_valid: got %b, expected 0", data_valid); end
        if (dout !== '0)          begin errors++; $display("FAIL midrst_dout: got %h, expected 0", dout); end
        if (wr_rst_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b, expected 1", wr_rst_busy); end
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checks += 2;
        if (wr_rst_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_clear: got %b, expected 0", wr_rst_busy); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL midrst_stale: got empty=%b, expected 1", empty); end
        wr_en = 1'b1; din = 32'h5EED0001; exp_q.push_back(32'h5EED0001);
        @(negedge clk_i);
        wr_en = 1'b0;
        @(negedge clk_i);
        drain(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL midrst_count: got %0d, expected 1", n); end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_underflow();
        test_streaming();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
